// File: rtl/fu_result_buf.sv
// fu_result_buf: per-functional-unit completion buffer feeding one CDB requester.
// Results from the FU are held in an order-preserving compacting queue. The oldest
// one is offered to the CDB until it is granted. Held entries are squashed or have
// their branch mask cleared by branch-resolve tasks while they wait.
// Optional macro FU_RESULT_BUF_BYPASS_EN: when the buffer is empty, an incoming
// result is offered to the CDB combinationally in the same cycle.

package fu_result_buf_pkg;

    typedef logic [3:0] BR_MASK;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_SQUASH = 2'd1,
        BR_CLEAR  = 2'd2,
        BR_OTHER  = 2'd3
    } BR_TASK;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  dest_tag;
        BR_MASK      b_mask;
        BR_MASK      b_id;
    } FU_PACKET;

    // The resolving branch's own result always survives its squash.
    function automatic logic pkt_squashed(input FU_PACKET p, input BR_TASK t, input BR_MASK id);
        return (t == BR_SQUASH) && ((p.b_mask & id) != '0) && (p.b_id != id);
    endfunction

    function automatic FU_PACKET pkt_filtered(input FU_PACKET p, input BR_TASK t, input BR_MASK id);
        FU_PACKET q;
        q = p;
        if (t == BR_CLEAR) begin
            q.b_mask = p.b_mask & ~id;
        end
        return q;
    endfunction

endpackage

module fu_result_buf
    import fu_result_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fu_valid,
    input  FU_PACKET         fu_pkt,
    output logic             fu_ready,
    output logic             cdb_req,
    output FU_PACKET         cdb_pkt,
    input  logic             cdb_stall,
    input  BR_TASK           rem_br_task,
    input  BR_MASK           rem_b_id,
    output logic [CNT_W-1:0] count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    FU_PACKET         slot      [DEPTH];
    FU_PACKET         slot_next [DEPTH];
    logic [CNT_W-1:0] count_next;

    logic     head_valid;
    logic     pop;
    logic     push;
    logic     push_dead;
    logic     bypass_taken;
    FU_PACKET push_pkt;

    assign head_valid = (count != '0);
    assign fu_ready   = reset && (count < CNT_W'(DEPTH));
    assign push       = fu_valid && fu_ready;
    assign pop        = head_valid && !cdb_stall;
    assign push_pkt   = pkt_filtered(fu_pkt, rem_br_task, rem_b_id);
    assign push_dead  = pkt_squashed(fu_pkt, rem_br_task, rem_b_id);

`ifdef FU_RESULT_BUF_BYPASS_EN
    logic bypass_live;

    assign bypass_live  = !head_valid && fu_valid && reset && !push_dead;
    assign bypass_taken = bypass_live && !cdb_stall;

    // Offer the held head, or the filtered incoming result when the buffer is empty.
    always_comb begin
        cdb_req = head_valid || bypass_live;
        cdb_pkt = '0;
        if (head_valid) begin
            cdb_pkt = slot[0];
        end else if (bypass_live) begin
            cdb_pkt = push_pkt;
        end
    end
`else
    assign bypass_taken = 1'b0;

    // Offer the held head straight from the registers.
    always_comb begin
        cdb_req = head_valid;
        cdb_pkt = head_valid ? slot[0] : '0;
    end
`endif

    // Pop the granted head, filter the rest, compact them, then append the new result.
    always_comb begin
        logic [CNT_W-1:0] wr;
        for (int i = 0; i < DEPTH; i++) begin
            slot_next[i] = '0;
        end
        wr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && !(pop && (i == 0)) &&
                !pkt_squashed(slot[i], rem_br_task, rem_b_id)) begin
                slot_next[wr[IDX_W-1:0]] = pkt_filtered(slot[i], rem_br_task, rem_b_id);
                wr = wr + CNT_W'(1);
            end
        end
        if (push && !bypass_taken && !push_dead) begin
            slot_next[wr[IDX_W-1:0]] = push_pkt;
            wr = wr + CNT_W'(1);
        end
        count_next = wr;
    end

    // Queue state register; an active-low reset flushes every slot.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
            end
        end else begin
            count <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= slot_next[i];
            end
        end
    end

endmodule

// File: tb/tb_fu_result_buf.sv
// Self-checking bench for fu_result_buf: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the buffer.
// Covers the FU_RESULT_BUF_BYPASS_EN variant when that macro is defined.

module tb_fu_result_buf;
    import fu_result_buf_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clock;
    logic             reset;
    logic             fu_valid;
    FU_PACKET         fu_pkt;
    logic             fu_ready;
    logic             cdb_req;
    FU_PACKET         cdb_pkt;
    logic             cdb_stall;
    BR_TASK           rem_br_task;
    BR_MASK           rem_b_id;
    logic [CNT_W-1:0] count;

    int n_compared   = 0;
    int n_mismatched = 0;

    FU_PACKET mq[$];
    logic     exp_ready;
    logic     exp_req;
    FU_PACKET exp_pkt;
    logic     exp_bypass;

    fu_result_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .fu_valid    (fu_valid),
        .fu_pkt      (fu_pkt),
        .fu_ready    (fu_ready),
        .cdb_req     (cdb_req),
        .cdb_pkt     (cdb_pkt),
        .cdb_stall   (cdb_stall),
        .rem_br_task (rem_br_task),
        .rem_b_id    (rem_b_id),
        .count       (count)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic FU_PACKET mk(input BR_MASK b_mask, input BR_MASK b_id);
        FU_PACKET p;
        p.result   = $urandom;
        p.dest_tag = 5'($urandom_range(0, 31));
        p.b_mask   = b_mask;
        p.b_id     = b_id;
        return p;
    endfunction

    // Reference rules for one result under the branch task on the inputs now.
    function automatic logic ref_killed(input FU_PACKET p);
        return (rem_br_task == BR_SQUASH) && ((p.b_mask & rem_b_id) != 4'b0) && (p.b_id != rem_b_id);
    endfunction

    function automatic FU_PACKET ref_cleared(input FU_PACKET p);
        FU_PACKET q;
        q = p;
        if (rem_br_task == BR_CLEAR) q.b_mask = p.b_mask & ~rem_b_id;
        return q;
    endfunction

    task automatic model_outputs();
        exp_ready  = reset && (mq.size() < DEPTH);
        exp_bypass = 1'b0;
        if (mq.size() > 0) begin
            exp_req = 1'b1;
            exp_pkt = mq[0];
        end else begin
            exp_req = 1'b0;
            exp_pkt = '0;
`ifdef FU_RESULT_BUF_BYPASS_EN
            if (fu_valid && reset && !ref_killed(fu_pkt)) begin
                exp_req    = 1'b1;
                exp_pkt    = ref_cleared(fu_pkt);
                exp_bypass = !cdb_stall;
            end
`endif
        end
    endtask

    task automatic model_update();
        FU_PACKET nq[$];
        logic     push;
        if (!reset) begin
            mq.delete();
        end else begin
            push = fu_valid && exp_ready && !exp_bypass;
            if (mq.size() > 0 && !cdb_stall) void'(mq.pop_front());
            foreach (mq[i]) if (!ref_killed(mq[i])) nq.push_back(ref_cleared(mq[i]));
            if (push && !ref_killed(fu_pkt)) nq.push_back(ref_cleared(fu_pkt));
            mq = nq;
        end
    endtask

    // One clock cycle: drive at negedge, compare before the posedge, advance model at it.
    task automatic apply_stimulus(input logic rst, input logic v, input FU_PACKET p,
                                  input logic st, input BR_TASK bt, input BR_MASK bid);
        @(negedge clock);
        reset       = rst;
        fu_valid    = v;
        fu_pkt      = p;
        cdb_stall   = st;
        rem_br_task = bt;
        rem_b_id    = bid;
        #1;
        model_outputs();
        check_output("fu_ready", 64'(fu_ready), 64'(exp_ready));
        check_output("cdb_req",  64'(cdb_req),  64'(exp_req));
        check_output("cdb_pkt",  64'(cdb_pkt),  64'(exp_pkt));
        check_output("count",    64'(count),    64'(mq.size()));
        @(posedge clock);
        model_update();
    endtask

    task automatic idle(input logic st);
        apply_stimulus(1'b1, 1'b0, '0, st, BR_NONE, 4'b0);
    endtask

    task automatic flush();
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, BR_NONE, 4'b0);
    endtask

    FU_PACKET pa, pb, pc, pd, pe, exp_b;
    logic     e_pending;

    initial begin
        reset       = 1'b0;
        fu_valid    = 1'b0;
        fu_pkt      = '0;
        cdb_stall   = 1'b1;
        rem_br_task = BR_NONE;
        rem_b_id    = 4'b0;

        // Reset held, then fill to full under stall.
        flush();
        flush();
        #1 check_output("rst_count", 64'(count), 64'd0);
        pa = mk(4'b0, 4'b0);
        pb = mk(4'b0, 4'b0);
        pc = mk(4'b0, 4'b0);
        pd = mk(4'b0, 4'b0);
        apply_stimulus(1'b1, 1'b1, pa, 1'b1, BR_NONE, 4'b0);
        apply_stimulus(1'b1, 1'b1, pb, 1'b1, BR_NONE, 4'b0);
        apply_stimulus(1'b1, 1'b1, pc, 1'b1, BR_NONE, 4'b0);
        apply_stimulus(1'b1, 1'b1, pd, 1'b1, BR_NONE, 4'b0);
        #1;
        check_output("full_count", 64'(count), 64'd4);
        check_output("full_ready", 64'(fu_ready), 64'd0);
        check_output("full_head", 64'(cdb_pkt), 64'(pa));

        // Drain while the FU holds E until it is accepted.
        pe = mk(4'b0, 4'b0);
        e_pending = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, e_pending, pe, 1'b0, BR_NONE, 4'b0);
            if (e_pending && exp_ready) e_pending = 1'b0;
        end
        #1;
        check_output("drain_count", 64'(count), 64'd1);
        check_output("drain_head", 64'(cdb_pkt), 64'(pe));

        // Squash in the middle of the queue keeps order of survivors.
        flush();
        pa = mk(4'b0000, 4'b0000);
        pb = mk(4'b0010, 4'b0000);
        pc = mk(4'b0010, 4'b0010);
        apply_stimulus(1'b1, 1'b1, pa, 1'b1, BR_NONE, 4'b0);
        apply_stimulus(1'b1, 1'b1, pb, 1'b1, BR_NONE, 4'b0);
        apply_stimulus(1'b1, 1'b1, pc, 1'b1, BR_NONE, 4'b0);
        apply_stimulus(1'b1, 1'b0, '0, 1'b1, BR_SQUASH, 4'b0010);
        #1;
        check_output("sq_count", 64'(count), 64'd2);
        check_output("sq_head", 64'(cdb_pkt), 64'(pa));
        idle(1'b0);
        #1;
        check_output("sq_next", 64'(cdb_pkt), 64'(pc));

        // Clear together with a pop.
        flush();
        pa = mk(4'b0100, 4'b0000);
        pb = mk(4'b0110, 4'b0000);
        apply_stimulus(1'b1, 1'b1, pa, 1'b1, BR_NONE, 4'b0);
        apply_stimulus(1'b1, 1'b1, pb, 1'b1, BR_NONE, 4'b0);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, BR_CLEAR, 4'b0100);
        exp_b = pb;
        exp_b.b_mask = 4'b0010;
        #1;
        check_output("clr_count", 64'(count), 64'd1);
        check_output("clr_head", 64'(cdb_pkt), 64'(exp_b));

        // Push squashed in the cycle it arrives.
        flush();
        apply_stimulus(1'b1, 1'b1, mk(4'b1000, 4'b0000), 1'b0, BR_SQUASH, 4'b1000);
        #1 check_output("sqpush_count", 64'(count), 64'd0);

`ifdef FU_RESULT_BUF_BYPASS_EN
        // Same-cycle bypass, then bypass under stall falls back to enqueue.
        pa = mk(4'b0001, 4'b0000);
        apply_stimulus(1'b1, 1'b1, pa, 1'b0, BR_NONE, 4'b0);
        #1 check_output("byp_count", 64'(count), 64'd0);
        apply_stimulus(1'b1, 1'b1, pa, 1'b1, BR_NONE, 4'b0);
        #1 check_output("byp_stall_count", 64'(count), 64'd1);
`endif

        // Randomized traffic against the reference model.
        flush();
        for (int n = 0; n < 400; n++) begin
            logic     r_rst;
            logic     r_v;
            logic     r_st;
            BR_TASK   r_bt;
            BR_MASK   r_id;
            BR_MASK   r_mask;
            BR_MASK   r_bid;
            r_rst  = ($urandom_range(0, 39) != 0);
            r_v    = ($urandom_range(0, 9) < 7);
            r_st   = ($urandom_range(0, 1) == 1);
            r_bt   = BR_TASK'($urandom_range(0, 3));
            r_id   = 4'b0001 << $urandom_range(0, 3);
            r_mask = 4'($urandom_range(0, 15));
            r_bid  = ($urandom_range(0, 2) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0;
            apply_stimulus(r_rst, r_v, mk(r_mask, r_bid), r_st, r_bt, r_id);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fu_result_buf.md
Name: fu_result_buf

Overview:
- Per-functional-unit completion buffer between an FU output and the CDB arbiter.
- Captures FU_PACKET results, presents the oldest one as a CDB request, and holds it until it is granted.
- Keeps entries squashed or mask-cleared while they wait, so only live results reach the CDB.
- Back-pressures the FU when the buffer is full; one instance per CDB requester.

Parameters:
- DEPTH, 4, number of buffered results; ≥ 2.
- CNT_W, $clog2(DEPTH+1), width of occupancy count.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low: state clears on a posedge where reset==0.
- fu_valid  in  1  FU presents a completed result this cycle.
- fu_pkt  in  FU_PACKET  completed result from the FU.
- fu_ready  out  1  buffer accepts fu_pkt this cycle.
- cdb_req  out  1  oldest entry valid; drives this FU's fu_done bit at the CDB.
- cdb_pkt  out  FU_PACKET  oldest entry; drives this FU's wr_data slot.
- cdb_stall  in  1  this FU's stall_sig bit from the CDB.
- rem_br_task  in  BR_TASK  branch resolve task: SQUASH / CLEAR / other.
- rem_b_id  in  BR_MASK  one-hot id of the resolving branch.
- count  out  CNT_W  current occupancy.

Behaviour:
- Storage: compacting queue slot[0..DEPTH-1]; slot[0] is oldest; order always preserved; occupancy in count.
- Reset (reset==0 at posedge): count=0, all slots '0.
  - Outputs after the edge: cdb_req=0, cdb_pkt='0, count=0.
  - fu_ready=0 in any cycle with reset==0; all inputs ignored.
- fu_ready = reset && (count < DEPTH). Registered-state only; no path from cdb_stall or fu_valid.
- push = fu_valid && fu_ready. fu_valid while !fu_ready is dropped; the FU must hold its packet.
- cdb_req = (count != 0). cdb_pkt = slot[0] when count != 0, else '0. Both come purely from registers.
- pop = cdb_req && !cdb_stall. The CDB asserts stall only for ungranted requesters, so !cdb_stall with cdb_req means granted.
- Next-state order within one edge:
  1. Remove slot[0] if pop.
  2. Apply branch task to the remaining entries and to the incoming push packet.
  3. Compact the survivors.
  4. Append the surviving push packet at the tail.
- SQUASH: drop any entry with (b_mask & rem_b_id) != 0 and b_id != rem_b_id. The resolving branch's own entry survives.
- CLEAR: entries with (b_mask & rem_b_id) != 0 get b_mask &= ~rem_b_id. The entry is kept.
- Other task values: entries unchanged.
- The popped head is not re-filtered; the CDB applies its own filtering.
- Latency: push at edge t, cdb_req visible in cycle t+1. Minimum residence is 1 cycle.
- Full: push not possible, even if pop occurs the same cycle. Pop frees a slot; fu_ready rises the next cycle.
- Empty with a push: count becomes 1 and the entry is at the head.
- Simultaneous push + pop + SQUASH: count_next = count − pop − squashed_held + (push && !push_squashed).
- Reset mid-operation flushes all entries; held results are lost.
- Invariants:
  - count ≤ DEPTH.
  - Slots at index ≥ count are '0.
  - No entry carries a b_mask bit equal to a CLEARed id after that edge.

Optional Feature:
- Macro: FU_RESULT_BUF_BYPASS_EN.
- Defined: when count==0 and fu_valid && reset, the incoming packet is filtered by the current-cycle branch task and presented combinationally.
  - cdb_req=1 and cdb_pkt=filtered fu_pkt in the same cycle, unless SQUASH kills it.
  - If not stalled, it is consumed and not enqueued; if stalled, it is enqueued normally.
  - Adds a combinational fu_valid→cdb_req path.
- Undefined: strict 1-cycle latency as above; no input-to-output combinational path.

Test Plan:
1. Reset then fill: hold reset=0 for 2 cycles → fu_ready=0, count=0. Release, push pkts A,B,C,D on consecutive cycles with cdb_stall=1 → count=4, fu_ready=0, cdb_pkt=A.
2. Full drain: from (1), cdb_stall=0 for 4 cycles with fu_valid=1, pkt E → cdb_pkt sequence A,B,C,D. E is accepted only once fu_ready=1 again (cycle after first pop). Final count=1 holding E.
3. Squash in middle: queue A(b_mask=0), B(b_mask=4'b0010, b_id=0), C(b_id=4'b0010, b_mask=4'b0010); SQUASH rem_b_id=4'b0010 with stall=1 → B removed, A,C kept in order, count 3→2.
4. Clear plus pop: queue A(b_mask=4'b0100), B(b_mask=4'b0110); CLEAR rem_b_id=4'b0100 with pop → next cdb_pkt=B with b_mask=4'b0010, count=1.
5. Same-cycle squash of push: empty buffer, push X(b_mask=4'b1000) with SQUASH rem_b_id=4'b1000 → count stays 0, cdb_req=0.
   - With FU_RESULT_BUF_BYPASS_EN: cdb_req=0 that cycle.
6. Bypass: FU_RESULT_BUF_BYPASS_EN defined, empty, push Y with stall=0 → cdb_req=1 and cdb_pkt=Y same cycle, count stays 0. Repeat with stall=1 → count=1 next cycle.
